// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if: valid/ready instruction-in / immediate-out bus of imm_gen_stage
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [ILEN-1:0]  in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered, skid-buffered immediate generator for the decode path
module imm_gen_stage #(
    parameter int XLEN     = 32,
    parameter int ILEN     = 32,
    parameter int TAG_W    = 32,
    parameter int EN_ZICSR = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    imm_gen_stage_if.slave   bus,
    output logic [CNT_W-1:0] illegal_cnt
);
    if ((XLEN != 32 && XLEN != 64) || ILEN != 32) begin : g_bad_param
        $fatal(1, "imm_gen_stage: XLEN must be 32 or 64 and ILEN must be 32");
    end

    typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z} fmt_e;

    typedef struct packed {
        logic             v;
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } ent_t;

    logic [31:0]      ins;
    logic [6:0]       opc;
    logic [2:0]       f3;
    fmt_e             fmt;
    logic             ill;
    logic [31:0]      imm32;
    logic             acc;
    ent_t             dec, o_q, o_d, s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign ins = bus.in_instr;
    assign opc = ins[6:0];
    assign f3  = ins[14:12];

    // opcode classification; anything illegal collapses to NONE
    always_comb begin
        fmt = FMT_NONE;
        ill = 1'b0;
        case (opc)
            7'h03, 7'h13, 7'h67: fmt = FMT_I;
            7'h23:               fmt = FMT_S;
            7'h63:               fmt = FMT_B;
            7'h37, 7'h17:        fmt = FMT_U;
            7'h6F:               fmt = FMT_J;
            7'h33, 7'h0F:        fmt = FMT_NONE;
            7'h73:               fmt = (EN_ZICSR != 0 && f3 != 3'b000) ? FMT_Z : FMT_I;
            default:             ill = 1'b1;
        endcase
        if (XLEN == 32 && opc == 7'h13 && f3[1:0] == 2'b01 && ins[25])
            ill = 1'b1;
        if (ill)
            fmt = FMT_NONE;
    end

    // 32-bit immediate per format; widened to XLEN by sign extension below
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = 32'($signed(ins[31:20]));
            FMT_S:   imm32 = 32'($signed({ins[31:25], ins[11:7]}));
            FMT_B:   imm32 = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            FMT_U:   imm32 = {ins[31:12], 12'b0};
            FMT_J:   imm32 = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            FMT_Z:   imm32 = {27'b0, ins[19:15]};
            default: imm32 = '0;
        endcase
    end

    assign dec = '{1'b1, XLEN'($signed(imm32)), fmt, ill, bus.in_tag};
    assign acc = bus.in_valid && !s_q.v;

    // output/skid steering: skid always drains first to keep order; flush wins over everything
    always_comb begin
        o_d   = o_q;
        s_d   = s_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            o_d.v = 1'b0;
            s_d.v = 1'b0;
        end else begin
            if (!o_q.v || bus.out_ready) begin
                if (s_q.v) begin
                    o_d   = s_q;
                    s_d.v = 1'b0;
                end else if (acc) begin
                    o_d = dec;
                end else begin
                    o_d.v = 1'b0;
                end
            end else if (acc) begin
                s_d = dec;
            end
            if (acc && ill && cnt_q != '1)
                cnt_d = cnt_q + 1'b1;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q   <= '0;
            s_q   <= '0;
            cnt_q <= '0;
        end else begin
            o_q   <= o_d;
            s_q   <= s_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready    = !s_q.v;
    assign bus.out_valid   = o_q.v;
    assign bus.out_imm     = o_q.imm;
    assign bus.out_fmt     = o_q.fmt;
    assign bus.out_illegal = o_q.ill;
    assign bus.out_tag     = o_q.tag;
    assign illegal_cnt     = cnt_q;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: three configurations of imm_gen_stage checked against a behavioural model
module tb_imm_gen_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_tag = '0;
    logic [15:0] cnt32, cnt64;
    logic [1:0]  cnt2;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [31:0] w;
        logic [31:0] tag;
    } item_t;

    item_t q[$];
    int    c32 = 0, c64 = 0, c2 = 0;

    imm_gen_stage_if #(.XLEN(32)) b32();
    imm_gen_stage_if #(.XLEN(64)) b64();
    imm_gen_stage_if #(.XLEN(32)) bc2();

    assign b32.in_valid = in_valid;
    assign b32.in_instr = in_instr;
    assign b32.in_tag = in_tag;
    assign b32.out_ready = out_ready;
    assign b64.in_valid = in_valid;
    assign b64.in_instr = in_instr;
    assign b64.in_tag = in_tag;
    assign b64.out_ready = out_ready;
    assign bc2.in_valid = in_valid;
    assign bc2.in_instr = in_instr;
    assign bc2.in_tag = in_tag;
    assign bc2.out_ready = out_ready;

    imm_gen_stage #(.XLEN(32)) u32 (.clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(b32), .illegal_cnt(cnt32));
    imm_gen_stage #(.XLEN(64)) u64 (.clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(b64), .illegal_cnt(cnt64));
    imm_gen_stage #(.XLEN(32), .EN_ZICSR(0), .CNT_W(2)) uc2 (.clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(bc2), .illegal_cnt(cnt2));

    always #5 clk = ~clk;

    // reference decode from field arithmetic
    function automatic void ref_dec(input logic [31:0] w, input int xlen, input bit zicsr,
                                    output logic [63:0] imm, output logic [2:0] fmt, output bit ill);
        int op, f3;
        op = int'(w[6:0]);
        f3 = int'(w[14:12]);
        imm = 64'd0;
        fmt = 3'd0;
        ill = (w[1:0] != 2'b11);
        if (op == 'h03 || op == 'h13 || op == 'h67 || (op == 'h73 && !(zicsr && f3 != 0))) begin
            fmt = 3'd1;
            imm = 64'(w[31:20]) - (w[31] ? 64'd4096 : 64'd0);
        end else if (op == 'h23) begin
            fmt = 3'd2;
            imm = 64'(w[31:25]) * 64'd32 + 64'(w[11:7]) - (w[31] ? 64'd4096 : 64'd0);
        end else if (op == 'h63) begin
            fmt = 3'd3;
            imm = 64'(w[7]) * 64'd2048 + 64'(w[30:25]) * 64'd32 + 64'(w[11:8]) * 64'd2 - (w[31] ? 64'd4096 : 64'd0);
        end else if (op == 'h37 || op == 'h17) begin
            fmt = 3'd4;
            imm = 64'(w[31:12]) * 64'd4096 - (w[31] ? 64'h1_0000_0000 : 64'd0);
        end else if (op == 'h6F) begin
            fmt = 3'd5;
            imm = 64'(w[19:12]) * 64'd4096 + 64'(w[20]) * 64'd2048 + 64'(w[30:21]) * 64'd2 - (w[31] ? 64'h10_0000 : 64'd0);
        end else if (op == 'h73) begin
            fmt = 3'd6;
            imm = 64'(w[19:15]);
        end else if (!(op == 'h33 || op == 'h0F)) begin
            ill = 1'b1;
        end
        if (xlen == 32 && op == 'h13 && (f3 == 1 || f3 == 5) && w[25])
            ill = 1'b1;
        if (ill) begin
            imm = 64'd0;
            fmt = 3'd0;
        end
        if (xlen == 32)
            imm = imm & 64'hFFFF_FFFF;
    endfunction

    // advance one clock, updating the 2-deep FIFO model from pre-edge inputs
    task automatic tick();
        bit          rdy;
        bit          ov;
        logic [63:0] im;
        logic [2:0]  f;
        bit          il32, il64;
        rdy = q.size() < 2;
        ov = q.size() > 0;
        if (flush) begin
            q.delete();
        end else begin
            if (ov && out_ready)
                void'(q.pop_front());
            if (in_valid && rdy) begin
                q.push_back('{in_instr, in_tag});
                ref_dec(in_instr, 32, 1'b1, im, f, il32);
                ref_dec(in_instr, 64, 1'b1, im, f, il64);
                if (il32) begin
                    c32++;
                    if (c2 < 3)
                        c2++;
                end
                if (il64)
                    c64++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        q.delete();
        c32 = 0;
        c64 = 0;
        c2 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] tag);
        in_valid = 1'b1;
        in_instr = w;
        in_tag = tag;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hs: valid=%b ready=%b exp 0/1", b32.out_valid, b32.in_ready);
        end
        checks++;
        if (b32.out_imm !== 32'd0 || b32.out_fmt !== 3'd0 || b32.out_illegal !== 1'b0 || b32.out_tag !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: imm=%h fmt=%0d ill=%b tag=%h exp zeros", b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag);
        end
        checks++;
        if (cnt32 !== 16'd0 || b64.out_imm !== 64'd0) begin
            failures++;
            $display("FAIL reset_cnt: cnt=%0d imm64=%h exp 0", cnt32, b64.out_imm);
        end
        do_reset();
    endtask

    task automatic test_decode();
        logic [31:0] tw[9]  = '{32'hFFF00093, 32'h80000063, 32'h001000EF, 32'h300FD0F3, 32'h800000B7,
                                32'h02009093, 32'h00000000, 32'hFE112E23, 32'h00208033};
        logic [31:0] e32[9] = '{32'hFFFFFFFF, 32'hFFFFF000, 32'h00000800, 32'h0000001F, 32'h80000000,
                                32'h0, 32'h0, 32'hFFFFFFFC, 32'h0};
        logic [2:0]  f32[9] = '{3'd1, 3'd3, 3'd5, 3'd6, 3'd4, 3'd0, 3'd0, 3'd2, 3'd0};
        logic        i32[9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        logic [63:0] e64[9] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFF000, 64'h800, 64'h1F, 64'hFFFFFFFF80000000,
                                64'h20, 64'h0, 64'hFFFFFFFFFFFFFFFC, 64'h0};
        logic [2:0]  f64[9] = '{3'd1, 3'd3, 3'd5, 3'd6, 3'd4, 3'd1, 3'd0, 3'd2, 3'd0};
        logic        i64[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic [31:0] ez[9]  = '{32'hFFFFFFFF, 32'hFFFFF000, 32'h00000800, 32'h00000300, 32'h80000000,
                                32'h0, 32'h0, 32'hFFFFFFFC, 32'h0};
        logic [2:0]  fz[9]  = '{3'd1, 3'd3, 3'd5, 3'd1, 3'd4, 3'd0, 3'd0, 3'd2, 3'd0};
        for (int i = 0; i < 9; i++) begin
            send(tw[i], 32'h100 + 32'(i * 4));
            checks++;
            if (b32.out_valid !== 1'b1 || b32.out_imm !== e32[i] || b32.out_fmt !== f32[i]
                || b32.out_illegal !== i32[i] || b32.out_tag !== 32'h100 + 32'(i * 4)) begin
                failures++;
                $display("FAIL dec32[%0d] %h: v=%b imm=%h fmt=%0d ill=%b tag=%h exp imm=%h fmt=%0d ill=%b",
                         i, tw[i], b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag, e32[i], f32[i], i32[i]);
            end
            checks++;
            if (b64.out_imm !== e64[i] || b64.out_fmt !== f64[i] || b64.out_illegal !== i64[i]) begin
                failures++;
                $display("FAIL dec64[%0d] %h: imm=%h fmt=%0d ill=%b exp imm=%h fmt=%0d ill=%b",
                         i, tw[i], b64.out_imm, b64.out_fmt, b64.out_illegal, e64[i], f64[i], i64[i]);
            end
            checks++;
            if (bc2.out_imm !== ez[i] || bc2.out_fmt !== fz[i]) begin
                failures++;
                $display("FAIL dec_nozicsr[%0d] %h: imm=%h fmt=%0d exp imm=%h fmt=%0d", i, tw[i], bc2.out_imm, bc2.out_fmt, ez[i], fz[i]);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (b32.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain: out_valid=%b exp 0", b32.out_valid);
        end
    endtask

    task automatic test_illegal_cnt();
        do_reset();
        send(32'h00000000, 32'h1);
        send(32'h02009093, 32'h2);
        checks++;
        if (cnt32 !== 16'd2 || cnt2 !== 2'd2 || cnt64 !== 16'd1) begin
            failures++;
            $display("FAIL cnt_two: cnt32=%0d cnt2=%0d cnt64=%0d exp 2/2/1", cnt32, cnt2, cnt64);
        end
        send(32'h0000007F, 32'h3);
        send(32'h00000001, 32'h4);
        send(32'h12345678, 32'h5);
        checks++;
        if (cnt32 !== 16'd5 || cnt2 !== 2'd3 || cnt64 !== 16'd4) begin
            failures++;
            $display("FAIL cnt_sat: cnt32=%0d cnt2=%0d cnt64=%0d exp 5/3/4", cnt32, cnt2, cnt64);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'hFFF00093;
        in_tag = 32'hA;
        tick();
        checks++;
        if (b32.in_ready !== 1'b1 || b32.out_tag !== 32'hA) begin
            failures++;
            $display("FAIL b2b_a: ready=%b tag=%h exp 1/A", b32.in_ready, b32.out_tag);
        end
        in_instr = 32'h80000063;
        in_tag = 32'hB;
        tick();
        checks++;
        if (b32.in_ready !== 1'b0 || b32.out_tag !== 32'hA) begin
            failures++;
            $display("FAIL b2b_b: ready=%b tag=%h exp 0/A", b32.in_ready, b32.out_tag);
        end
        in_instr = 32'h001000EF;
        in_tag = 32'hC;
        tick();
        tick();
        checks++;
        if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1 || b32.out_tag !== 32'hA || b32.out_imm !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL b2b_hold: ready=%b v=%b tag=%h imm=%h exp 0/1/A/FFFFFFFF", b32.in_ready, b32.out_valid, b32.out_tag, b32.out_imm);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (b32.out_tag !== 32'hB || b32.out_fmt !== 3'd3 || b32.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_out_b: tag=%h fmt=%0d ready=%b exp B/3/1", b32.out_tag, b32.out_fmt, b32.in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (b32.out_valid !== 1'b1 || b32.out_tag !== 32'hC || b32.out_imm !== 32'h800) begin
            failures++;
            $display("FAIL b2b_out_c: v=%b tag=%h imm=%h exp 1/C/800", b32.out_valid, b32.out_tag, b32.out_imm);
        end
        tick();
        checks++;
        if (b32.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: v=%b exp 0 (duplicate)", b32.out_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1;
        in_instr = 32'hFFF00093;
        in_tag = 32'h11;
        tick();
        in_tag = 32'h22;
        tick();
        flush = 1'b1;
        in_instr = 32'h00000000;
        in_tag = 32'hDD;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || cnt32 !== 16'd0) begin
            failures++;
            $display("FAIL flush: v=%b ready=%b cnt=%0d exp 0/1/0", b32.out_valid, b32.in_ready, cnt32);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (b32.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_ghost: v=%b tag=%h exp no output", b32.out_valid, b32.out_tag);
            end
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        in_tag = 32'h33;
        tick();
        in_instr = 32'hFFF00093;
        in_tag = 32'h44;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || b32.out_tag !== 32'd0 || cnt32 !== 16'd0) begin
            failures++;
            $display("FAIL rst_mid: v=%b ready=%b tag=%h cnt=%0d exp 0/1/0/0", b32.out_valid, b32.in_ready, b32.out_tag, cnt32);
        end
        q.delete();
        c32 = 0;
        c64 = 0;
        c2 = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0]  ops[11] = '{8'h03, 8'h13, 8'h17, 8'h23, 8'h33, 8'h37, 8'h63, 8'h67, 8'h6F, 8'h0F, 8'h73};
        logic [63:0] e32, e64, ez;
        logic [2:0]  f32, f64, fz;
        bit          i32, i64, iz;
        int          k;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 40) == 0);
            in_instr = $urandom;
            k = $urandom_range(0, 13);
            if (k < 11)
                in_instr[6:0] = ops[k][6:0];
            in_tag = $urandom;
            tick();
            checks++;
            if (b32.out_valid !== (q.size() > 0) || b64.out_valid !== (q.size() > 0) || bc2.out_valid !== (q.size() > 0)
                || b32.in_ready !== (q.size() < 2)) begin
                failures++;
                $display("FAIL rnd_flow@%0d: v=%b/%b/%b ready=%b exp depth=%0d", n, b32.out_valid, b64.out_valid, bc2.out_valid, b32.in_ready, q.size());
            end
            if (q.size() > 0) begin
                ref_dec(q[0].w, 32, 1'b1, e32, f32, i32);
                ref_dec(q[0].w, 64, 1'b1, e64, f64, i64);
                ref_dec(q[0].w, 32, 1'b0, ez, fz, iz);
                checks++;
                if (b32.out_imm !== e32[31:0] || b32.out_fmt !== f32 || b32.out_illegal !== i32 || b32.out_tag !== q[0].tag) begin
                    failures++;
                    $display("FAIL rnd32@%0d %h: imm=%h fmt=%0d ill=%b tag=%h exp %h/%0d/%b/%h",
                             n, q[0].w, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag, e32[31:0], f32, i32, q[0].tag);
                end
                checks++;
                if (b64.out_imm !== e64 || b64.out_fmt !== f64 || b64.out_illegal !== i64 || b64.out_tag !== q[0].tag) begin
                    failures++;
                    $display("FAIL rnd64@%0d %h: imm=%h fmt=%0d ill=%b exp %h/%0d/%b", n, q[0].w, b64.out_imm, b64.out_fmt, b64.out_illegal, e64, f64, i64);
                end
                checks++;
                if (bc2.out_imm !== ez[31:0] || bc2.out_fmt !== fz || bc2.out_illegal !== iz) begin
                    failures++;
                    $display("FAIL rnd_nozicsr@%0d %h: imm=%h fmt=%0d exp %h/%0d", n, q[0].w, bc2.out_imm, bc2.out_fmt, ez[31:0], fz);
                end
            end
            checks++;
            if (cnt32 !== 16'(c32) || cnt64 !== 16'(c64) || cnt2 !== 2'(c2)) begin
                failures++;
                $display("FAIL rnd_cnt@%0d: %0d/%0d/%0d exp %0d/%0d/%0d", n, cnt32, cnt64, cnt2, c32, c64, c2);
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_decode();
        test_illegal_cnt();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
